wallace_multiplier: RTL and testbench



---
 rtl/mult_pkg.sv | 87 ++++++++
 rtl/wallace_fa.sv | 14 +
 rtl/wallace_multiplier.sv | 123 ++++++++++++
 tb/tb_wallace_multiplier.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared constants and elaboration-time helpers for the Wallace multiplier.
// The helpers describe the shape of the reduction tree: how many bits sit in
// each column at each level and where each column starts in a level's
// flattened bit vector. The RTL uses them to wire full and half adders.
package mult_pkg;

  localparam int OP_W    = 8;
  localparam int PROD_W  = 16;
  localparam int MAX_LVL = 12;

  // Number of full adders applied to a column holding h bits.
  // Columns already at two bits or fewer are left alone.
  function automatic int n_fa(input int h);
    return (h >= 3) ? h / 3 : 0;
  endfunction

  // A leftover pair after grouping by three goes through one half adder.
  function automatic int n_ha(input int h);
    return (h >= 3 && (h % 3) == 2) ? 1 : 0;
  endfunction

  // Bits that travel unchanged to the next level in the same column.
  function automatic int n_pass(input int h);
    if (h < 3) return h;
    return ((h % 3) == 1) ? 1 : 0;
  endfunction

  // Bits a column keeps in its own position at the next level.
  function automatic int n_out(input int h);
    return n_fa(h) + n_ha(h) + n_pass(h);
  endfunction

  // Bits a column pushes into the column above it at the next level.
  function automatic int n_carry(input int h);
    return n_fa(h) + n_ha(h);
  endfunction

  // Partial-product column heights before any reduction (1,2,..,8,..,2,1,0).
  function automatic int init_h(input int c);
    if (c < OP_W) return c + 1;
    if (c < 2 * OP_W - 1) return 2 * OP_W - 1 - c;
    return 0;
  endfunction

  // Height of column c after s reduction levels.
  function automatic int col_h(input int s, input int c);
    int h  [PROD_W];
    int nh [PROD_W];
    for (int k = 0; k < PROD_W; k++) h[k] = init_h(k);
    for (int st = 0; st < s; st++) begin
      for (int k = 0; k < PROD_W; k++)
        nh[k] = n_out(h[k]) + ((k > 0) ? n_carry(h[k-1]) : 0);
      for (int k = 0; k < PROD_W; k++) h[k] = nh[k];
    end
    return h[c];
  endfunction

  // Tallest column at level s.
  function automatic int max_h(input int s);
    int m;
    m = 0;
    for (int k = 0; k < PROD_W; k++)
      if (col_h(s, k) > m) m = col_h(s, k);
    return m;
  endfunction

  // Number of reduction levels needed until every column holds <= 2 bits.
  function automatic int num_levels();
    for (int s = 0; s < MAX_LVL; s++)
      if (max_h(s) <= 2) return s;
    return MAX_LVL;
  endfunction

  // Bit offset of column c inside the flattened vector of level s.
  function automatic int col_off(input int s, input int c);
    int o;
    o = 0;
    for (int k = 0; k < c; k++) o += col_h(s, k);
    return o;
  endfunction

  // Total number of bits carried by level s.
  function automatic int lvl_w(input int s);
    return col_off(s, PROD_W);
  endfunction

endpackage

// File: rtl/wallace_fa.sv
// One-bit full adder used throughout the reduction tree. Half adders reuse
// it with cin tied low.
module wallace_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/wallace_multiplier.sv
// Unsigned 8x8 multiplier: a Wallace reduction tree squeezes the 64 partial
// product bits down to two 16-bit vectors, which are registered and then
// summed by a carry-propagate adder in a second register stage.
// Each reduction level is a flat vector whose column layout is computed by
// the package helpers, so every bit has exactly one driver and one reader.
module wallace_multiplier
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  output logic [PROD_W-1:0] product
);

  localparam int NLVL = num_levels();

  logic [PROD_W-1:0] sum_w;
  logic [PROD_W-1:0] carry_w;
  logic [PROD_W-1:0] sum_r;
  logic [PROD_W-1:0] carry_r;
  logic              v1;

  for (genvar s = 0; s <= NLVL; s++) begin : g_lvl
    logic [lvl_w(s)-1:0] v;

    if (s == 0) begin : g_pp
      // Level 0 holds the raw partial products, grouped by column weight.
      for (genvar i = 0; i < OP_W; i++) begin : g_row
        for (genvar j = 0; j < OP_W; j++) begin : g_bit
          localparam int C   = i + j;
          localparam int IDX = (C < OP_W) ? i : i - (C - (OP_W - 1));
          assign v[col_off(0, C) + IDX] = a[j] & b[i];
        end
      end
    end else begin : g_red
      // Each column of the previous level is grouped in threes through full
      // adders, a leftover pair through a half adder, and any single
      // remaining bit passes straight through. Sums stay in the column and
      // carries land in the next column after that column's own outputs.
      // The top column only ever collects carries and never exceeds two bits
      // for 8-bit operands, so no carry leaves the 16-bit range.
      for (genvar c = 0; c < PROD_W; c++) begin : g_col
        localparam int H    = col_h(s - 1, c);
        localparam int NF   = n_fa(H);
        localparam int NH   = n_ha(H);
        localparam int NP   = n_pass(H);
        localparam int SRC  = col_off(s - 1, c);
        localparam int DST  = col_off(s, c);
        localparam int CDST = (c < PROD_W - 1) ?
                              col_off(s, c + 1) + n_out(col_h(s - 1, c + 1)) : 0;

        for (genvar k = 0; k < NF; k++) begin : g_fa
          wallace_fa u_fa (
            .a    (g_lvl[s-1].v[SRC + 3*k]),
            .b    (g_lvl[s-1].v[SRC + 3*k + 1]),
            .cin  (g_lvl[s-1].v[SRC + 3*k + 2]),
            .sum  (v[DST + k]),
            .cout (v[CDST + k])
          );
        end

        if (NH == 1) begin : g_ha
          wallace_fa u_ha (
            .a    (g_lvl[s-1].v[SRC + 3*NF]),
            .b    (g_lvl[s-1].v[SRC + 3*NF + 1]),
            .cin  (1'b0),
            .sum  (v[DST + NF]),
            .cout (v[CDST + NF])
          );
        end

        for (genvar p = 0; p < NP; p++) begin : g_pass
          assign v[DST + NF + NH + p] = g_lvl[s-1].v[SRC + 3*NF + 2*NH + p];
        end
      end
    end
  end

  // Split the final level (at most two bits per column) into the sum and
  // carry vectors; missing bits are zero.
  for (genvar c = 0; c < PROD_W; c++) begin : g_out
    localparam int H   = col_h(NLVL, c);
    localparam int OFF = col_off(NLVL, c);
    if (H == 0) begin : g_h0
      assign sum_w[c]   = 1'b0;
      assign carry_w[c] = 1'b0;
    end else if (H == 1) begin : g_h1
      assign sum_w[c]   = g_lvl[NLVL].v[OFF];
      assign carry_w[c] = 1'b0;
    end else begin : g_h2
      assign sum_w[c]   = g_lvl[NLVL].v[OFF];
      assign carry_w[c] = g_lvl[NLVL].v[OFF + 1];
    end
  end

  // Stage 1: capture the reduced sum/carry pair and the input valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r   <= '0;
      carry_r <= '0;
      v1      <= 1'b0;
    end else begin
      sum_r   <= sum_w;
      carry_r <= carry_w;
      v1      <= in_valid;
    end
  end

  // Stage 2: final carry-propagate add; it cannot overflow 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product   <= '0;
      out_valid <= 1'b0;
    end else begin
      product   <= sum_r + carry_r;
      out_valid <= v1;
    end
  end

endmodule

// File: tb/tb_wallace_multiplier.sv
// Scoreboard bench for wallace_multiplier: the driver pushes a*b for every
// valid operand pair, and an independent monitor pops and compares whenever
// the DUT raises out_valid, also checking the two-cycle latency.
module tb_wallace_multiplier;

  typedef struct {
    logic [15:0] prod;
    int          issue;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic [15:0] product;

  exp_t sb_q[$];
  int   cyc;
  int   checks;
  int   errors;

  wallace_multiplier dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .product   (product)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running cycle counter used to timestamp issue and completion.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  // Drive one operand pair shortly after a rising edge; valid pairs record
  // their reference product and the cycle they were presented in.
  task automatic applyStimulus(input logic v, input logic [7:0] x,
                               input logic [7:0] y);
    int p;
    @(posedge clk);
    #2;
    in_valid = v;
    a        = x;
    b        = y;
    if (v) begin
      p = int'(x) * int'(y);
      sb_q.push_back('{prod: p[15:0], issue: cyc});
    end
  endtask

  // Monitor: compare every presented product against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          checkOutput("spurious_valid", 32'(out_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          checkOutput("product", 32'(product), 32'(e.prod));
          checkOutput("latency", 32'(cyc - e.issue), 32'd2);
        end
      end else if (sb_q.size() > 0 && (cyc - sb_q[0].issue) >= 2) begin
        checkOutput("missing_valid", 32'(out_valid), 32'd1);
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    cyc      = 0;
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = 8'h00;
    b        = 8'h00;

    #1;
    checkOutput("reset_product", 32'(product), 32'd0);
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Directed corners.
    applyStimulus(1'b1, 8'hFF, 8'hFF);
    applyStimulus(1'b1, 8'h00, 8'hA5);
    applyStimulus(1'b1, 8'h01, 8'hA5);
    applyStimulus(1'b1, 8'h80, 8'h02);
    applyStimulus(1'b1, 8'h80, 8'h80);
    applyStimulus(1'b1, 8'hFF, 8'h01);
    applyStimulus(1'b1, 8'hA5, 8'h00);

    // Three pairs, a one-cycle gap, then two more.
    applyStimulus(1'b1, 8'h12, 8'h34);
    applyStimulus(1'b1, 8'hC3, 8'h3C);
    applyStimulus(1'b1, 8'hFE, 8'hFD);
    applyStimulus(1'b0, 8'h77, 8'h99);
    applyStimulus(1'b1, 8'h0F, 8'hF0);
    applyStimulus(1'b1, 8'h81, 8'h7F);
    applyStimulus(1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);

    // Asynchronous reset between edges with operations in flight.
    applyStimulus(1'b1, 8'hFF, 8'hFF);
    applyStimulus(1'b1, 8'hEE, 8'hDD);
    @(posedge clk);
    #3;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    sb_q.delete();
    #1;
    checkOutput("async_reset_product", 32'(product), 32'd0);
    checkOutput("async_reset_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    applyStimulus(1'b1, 8'h33, 8'h44);
    applyStimulus(1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);

    // Random operands with random valid.
    for (int n = 0; n < 10000; n++)
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));

    // Exhaustive sweep of all operand pairs.
    for (int x = 0; x < 256; x++)
      for (int y = 0; y < 256; y++)
        applyStimulus(1'b1, 8'(x), 8'(y));
    applyStimulus(1'b0, 8'h00, 8'h00);

    repeat (5) @(posedge clk);
    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
